// File: rtl/serializer_pkg.sv
// Shared types and defaults for the parallel-to-serial transmitter.
// The serial format sends the MSB first and marks each bit with a valid strobe.
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_BUS_WIDTH = 16;
  localparam int unsigned DEF_MIN_LEN        = 3;

  // A modifier of zero selects a full-width word.
  function automatic int unsigned eff_len(input int unsigned mod, input int unsigned width);
    return (mod == 0) ? width : mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: latches one word and sends its top len bits MSB first,
// one bit per cycle with a valid strobe; busy mirrors the burst.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int unsigned MOD_WIDTH      = $clog2(DATA_BUS_WIDTH),
  parameter int unsigned MIN_LEN        = DEF_MIN_LEN
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [MOD_WIDTH-1:0]      data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam logic [MOD_WIDTH:0] CNT_ONE = (MOD_WIDTH + 1)'(1);

  state_t                    state;
  state_t                    state_next;
  logic [DATA_BUS_WIDTH-1:0] shift_q;
  logic [MOD_WIDTH:0]        cnt_q;
  int unsigned               len;
  logic                      accept;
  logic                      last_bit;

  assign len      = eff_len(32'(data_mod_i), DATA_BUS_WIDTH);
  assign accept   = data_val_i && (state == IDLE) && (len >= MIN_LEN);
  assign last_bit = (cnt_q == CNT_ONE);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SEND;
      SEND:    if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cnt_q holds the bits still to go including the one currently on the wire.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q <= data_i;
      cnt_q   <= (MOD_WIDTH + 1)'(len);
    end else if (state == SEND) begin
      shift_q <= {shift_q[DATA_BUS_WIDTH-2:0], 1'b0};
      cnt_q   <= cnt_q - CNT_ONE;
    end
  end

  // Outputs depend only on flops, so they behave as registered and clear with reset.
  always_comb begin
    busy_o         = 1'b0;
    ser_data_val_o = 1'b0;
    ser_data_o     = 1'b0;
    if (state == SEND) begin
      busy_o         = 1'b1;
      ser_data_val_o = 1'b1;
      ser_data_o     = shift_q[DATA_BUS_WIDTH-1];
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed scenarios plus random traffic compared
// against a queue-based model of the expected per-cycle serial output.
module tb_serializer;

  localparam int unsigned W    = 16;
  localparam int unsigned MW   = $clog2(W);
  localparam int unsigned MINL = 3;

  logic          clk   = 1'b0;
  logic          arstn = 1'b1;
  logic [W-1:0]  data  = '0;
  logic [MW-1:0] dmod  = '0;
  logic          dval  = 1'b0;
  logic          sdo;
  logic          sdv;
  logic          busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Expected {valid, bit} for each upcoming cycle; empty means idle.
  logic [1:0]   exp_q[$];
  logic         prev_val = 1'b0;
  logic [W-1:0] last_word = '0;
  int unsigned  last_len = 0;
  logic [W-1:0] col = '0;
  int unsigned  col_n = 0;

  serializer #(
    .DATA_BUS_WIDTH(W),
    .MOD_WIDTH     (MW),
    .MIN_LEN       (MINL)
  ) dut (
    .clk_i         (clk),
    .arstn_i       (arstn),
    .data_i        (data),
    .data_mod_i    (dmod),
    .data_val_i    (dval),
    .ser_data_o    (sdo),
    .ser_data_val_o(sdv),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Accept only when the previous cycle was idle and the request is long enough.
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic [MW-1:0] m,
                            output logic [1:0] e);
    int unsigned len;
    len = (m == 0) ? W : int'(m);
    if (!prev_val && v && len >= MINL) begin
      for (int k = 0; k < int'(len); k++) exp_q.push_back({1'b1, d[W-1-k]});
      last_word = d;
      last_len  = len;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
    prev_val = e[1];
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [MW-1:0] m);
    logic [1:0] e;
    dval = v;
    data = d;
    dmod = m;
    @(posedge clk);
    model_edge(v, d, m, e);
    @(negedge clk);
    check("out{val,bit,busy}", {29'd0, sdv, sdo, busy}, {29'd0, e[1], e[0], e[1]});
    if (sdv) begin
      col = {col[W-2:0], sdo};
      col_n++;
    end else if (col_n != 0) begin
      check("burst_len", col_n, last_len);
      if (col_n == W) check("loopback", {16'd0, col}, {16'd0, last_word});
      col_n = 0;
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, data, dmod);
  endtask

  initial begin
    #1 arstn = 1'b0;
    #1;
    check("reset_out", {29'd0, sdv, sdo, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", {29'd0, sdv, sdo, busy}, 32'd0);
    arstn = 1'b1;

    // Full word
    cycle(1'b1, 16'hA5C3, 4'd0);
    idle(18);

    // Partial word
    cycle(1'b1, 16'hF000, 4'd5);
    idle(8);

    // Too-short requests are dropped, minimum length goes through
    cycle(1'b1, 16'hFFFF, 4'd1);
    idle(3);
    cycle(1'b1, 16'hFFFF, 4'd2);
    idle(3);
    cycle(1'b1, 16'h6000, 4'd3);
    idle(5);

    // Request during a burst is ignored; one in the bubble is accepted
    cycle(1'b1, 16'hFFFF, 4'd0);
    for (int i = 1; i < 16; i++) cycle(i == 4, (i == 4) ? 16'h0000 : 16'hFFFF, 4'd0);
    cycle(1'b0, 16'hFFFF, 4'd0);
    cycle(1'b1, 16'h1234, 4'd0);
    idle(18);

    // Asynchronous reset in the middle of a burst
    cycle(1'b1, 16'hFFFF, 4'd0);
    for (int i = 1; i <= 7; i++) cycle(1'b0, 16'hFFFF, 4'd0);
    dval = 1'b0;
    #2 arstn = 1'b0;
    #1;
    check("async_rst", {29'd0, sdv, sdo, busy}, 32'd0);
    exp_q.delete();
    prev_val = 1'b0;
    col_n    = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_held", {29'd0, sdv, sdo, busy}, 32'd0);
    arstn = 1'b1;
    idle(2);
    cycle(1'b1, 16'h8001, 4'd0);
    idle(18);

    // Valid held high with a fresh random word and length every cycle
    for (int i = 0; i < 1000; i++) cycle(1'b1, W'($urandom), MW'($urandom));
    // Sparse random requests
    for (int i = 0; i < 300; i++) cycle($urandom_range(0, 3) == 0, W'($urandom), MW'($urandom));
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
